// File: rtl/dm9000a_reg_access_pkg.sv
// Shared types for the DM9000A register access responder: FSM encoding, request latch, register indexes.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package dm9000a_reg_access_pkg;

   // SD bus width of the DM9000A in 16-bit mode
   localparam int BUS_W = 16;

   // Register indexes used by the control FSMs
   localparam logic [7:0] REG_NCR   = 8'h00;
   localparam logic [7:0] REG_NSR   = 8'h01;
   localparam logic [7:0] REG_GPR   = 8'h1F;
   localparam logic [7:0] REG_MRCMD = 8'hF2;
   localparam logic [7:0] REG_MWCMD = 8'hF8;
   localparam logic [7:0] REG_ISR   = 8'hFE;
   localparam logic [7:0] REG_IMR   = 8'hFF;

   // 4-bit state encodings; index phase then data phase, each SETUP/STROBE/RECOV
   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_IDX_SETUP  = 4'd1,
      ST_IDX_STROBE = 4'd2,
      ST_IDX_RECOV  = 4'd3,
      ST_DAT_SETUP  = 4'd4,
      ST_DAT_STROBE = 4'd5,
      ST_DAT_RECOV  = 4'd6,
      ST_DONE       = 4'd7
   } state_t;

   // Request captured in IDLE; everything after that runs from this copy
   typedef struct packed {
      logic             isWrite;
      logic [7:0]       regIdx;
      logic [BUS_W-1:0] data;
   } req_t;

   // Phase timer load value for a state: the state lasts (load + 1) clocks
   function automatic logic [3:0] phaseLoad(input state_t st,
                                            input logic [3:0] setupLen,
                                            input logic [3:0] strobeLen,
                                            input logic [3:0] recovLen);
      logic [3:0] len;
      len = 4'd1;
      case (st)
         ST_IDX_SETUP,  ST_DAT_SETUP:  len = setupLen;
         ST_IDX_STROBE, ST_DAT_STROBE: len = strobeLen;
         ST_IDX_RECOV,  ST_DAT_RECOV:  len = recovLen;
         default:                      len = 4'd1;
      endcase
      return len - 4'd1;
   endfunction

endpackage

// File: rtl/dm9000a_reg_access_bus_timer.sv
// Phase down-counter: load on state change, count to zero, zero flags the last clock of the phase.
// Latency: zero is valid the clock after load (load value 0 gives a one-clock phase).
// Backpressure: none; free-running once loaded, holds at zero.
module dm9000a_reg_access_bus_timer (
   input  logic       iDm9000aClk,
   input  logic       iReset,
   input  logic       load,
   input  logic [3:0] loadVal,
   output logic       zero
);

   logic [3:0] count;

   // Load takes priority; otherwise count down and park at zero
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         count <= 4'd0;
      end else if (load) begin
         count <= loadVal;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/dm9000a_reg_access.sv
// DM9000A register IOR/IOW responder: one request -> index write (CMD=0) then data write/read (CMD=1).
// Latency: RunEnd rises 2*(S+W+R)+1 clocks after the request is sampled; (S+W+R)+1 on an index-cache hit.
// Backpressure: 4-phase handshake; RunStart held until RunEnd, RunEnd held until RunStart falls.
// Optional: DM9000A_INDEX_CACHE_EN skips the index phase when the index matches the last one written.
module dm9000a_reg_access
   import dm9000a_reg_access_pkg::*;
#(
   parameter int SETUP_CYCLES    = 1,
   parameter int STROBE_CYCLES   = 2,
   parameter int RECOVERY_CYCLES = 2
) (
   input  logic             iDm9000aClk,
   input  logic             iReset,
   input  logic             iIowRunStart,
   input  logic [15:0]      iIowReg,
   input  logic [15:0]      iIowData,
   output logic             oIowRunEnd,
   input  logic             iIorRunStart,
   input  logic [15:0]      iIorReg,
   output logic             oIorRunEnd,
   output logic [15:0]      oIorReturnValue,
   output logic             oDmCmd,
   output logic             oDmCs_n,
   output logic             oDmIor_n,
   output logic             oDmIow_n,
   output logic [BUS_W-1:0] oSdOut,
   output logic             oSdOe,
   input  logic [BUS_W-1:0] iSdIn
);

   localparam logic [3:0] SETUP_LEN  = 4'(SETUP_CYCLES);
   localparam logic [3:0] STROBE_LEN = 4'(STROBE_CYCLES);
   localparam logic [3:0] RECOV_LEN  = 4'(RECOVERY_CYCLES);

   state_t           state;
   state_t           stateNext;
   req_t             req;

   logic             startAny;
   logic [7:0]       startReg;
   logic             latchedStart;
   logic             cacheHit;

   logic             timerLoad;
   logic [3:0]       timerLoadVal;
   logic             timerZero;

   logic             cmdNext;
   logic             csNext;
   logic             iorNext;
   logic             iowNext;
   logic             oeNext;
   logic [BUS_W-1:0] sdNext;
   logic             iowEndNext;
   logic             iorEndNext;

   // Only the low byte of a register index reaches the bus
   logic             unusedRegHi;
   assign unusedRegHi = ^{iIowReg[15:8], iIorReg[15:8]};

   // Request arbitration: write wins when both are raised together
   always_comb begin
      startAny = iIowRunStart | iIorRunStart;
      startReg = iIowRunStart ? iIowReg[7:0] : iIorReg[7:0];
   end

   // RunStart of the operation currently owned by the FSM
   assign latchedStart = req.isWrite ? iIowRunStart : iIorRunStart;

`ifdef DM9000A_INDEX_CACHE_EN
   logic       cacheVld;
   logic [7:0] cacheIdx;

   // Remember the index once its write has fully completed on the pins
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         cacheVld <= 1'b0;
         cacheIdx <= 8'h00;
      end else if (state == ST_IDX_RECOV && timerZero) begin
         cacheVld <= 1'b1;
         cacheIdx <= req.regIdx;
      end
   end

   assign cacheHit = cacheVld && (cacheIdx == startReg);
`else
   assign cacheHit = 1'b0;
`endif

   // State register
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state: each bus phase ends when its timer reaches zero
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: begin
            if (startAny) begin
               stateNext = cacheHit ? ST_DAT_SETUP : ST_IDX_SETUP;
            end
         end
         ST_IDX_SETUP:  if (timerZero) stateNext = ST_IDX_STROBE;
         ST_IDX_STROBE: if (timerZero) stateNext = ST_IDX_RECOV;
         ST_IDX_RECOV:  if (timerZero) stateNext = ST_DAT_SETUP;
         ST_DAT_SETUP:  if (timerZero) stateNext = ST_DAT_STROBE;
         ST_DAT_STROBE: if (timerZero) stateNext = ST_DAT_RECOV;
         ST_DAT_RECOV:  if (timerZero) stateNext = ST_DONE;
         ST_DONE:       if (!latchedStart) stateNext = ST_IDLE;
         default:       stateNext = ST_IDLE;
      endcase
   end

   // Reload the phase timer with the length of the state being entered
   always_comb begin
      timerLoad    = (stateNext != state);
      timerLoadVal = phaseLoad(stateNext, SETUP_LEN, STROBE_LEN, RECOV_LEN);
   end

   dm9000a_reg_access_bus_timer uBusTimer (
      .iDm9000aClk (iDm9000aClk),
      .iReset      (iReset),
      .load        (timerLoad),
      .loadVal     (timerLoadVal),
      .zero        (timerZero)
   );

   // Capture the request; fields are ignored for the rest of the cycle
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         req <= '0;
      end else if (state == ST_IDLE && startAny) begin
         req.isWrite <= iIowRunStart;
         req.regIdx  <= startReg;
         req.data    <= iIowData;
      end
   end

   // Pin values for the current state; CMD and SD hold between cycles
   always_comb begin
      cmdNext    = oDmCmd;
      sdNext     = oSdOut;
      csNext     = 1'b1;
      iorNext    = 1'b1;
      iowNext    = 1'b1;
      oeNext     = 1'b0;
      iowEndNext = 1'b0;
      iorEndNext = 1'b0;
      case (state)
         ST_IDX_SETUP, ST_IDX_STROBE, ST_IDX_RECOV: begin
            cmdNext = 1'b0;
            sdNext  = {{(BUS_W-8){1'b0}}, req.regIdx};
            oeNext  = 1'b1;
            csNext  = (state == ST_IDX_RECOV);
            iowNext = (state != ST_IDX_STROBE);
         end
         ST_DAT_SETUP, ST_DAT_STROBE, ST_DAT_RECOV: begin
            cmdNext = 1'b1;
            csNext  = (state == ST_DAT_RECOV);
            if (req.isWrite) begin
               sdNext  = req.data;
               oeNext  = 1'b1;
               iowNext = (state != ST_DAT_STROBE);
            end else begin
               iorNext = (state != ST_DAT_STROBE);
            end
         end
         ST_DONE: begin
            iowEndNext = req.isWrite;
            iorEndNext = !req.isWrite;
         end
         default: begin
         end
      endcase
   end

   // Registered pins so strobes and selects never glitch
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         oDmCmd     <= 1'b0;
         oDmCs_n    <= 1'b1;
         oDmIor_n   <= 1'b1;
         oDmIow_n   <= 1'b1;
         oSdOut     <= '0;
         oSdOe      <= 1'b0;
         oIowRunEnd <= 1'b0;
         oIorRunEnd <= 1'b0;
      end else begin
         oDmCmd     <= cmdNext;
         oDmCs_n    <= csNext;
         oDmIor_n   <= iorNext;
         oDmIow_n   <= iowNext;
         oSdOut     <= sdNext;
         oSdOe      <= oeNext;
         oIowRunEnd <= iowEndNext;
         oIorRunEnd <= iorEndNext;
      end
   end

   // Sample SD on the last clock IOR# is low, i.e. at the strobe's rising edge
   always_ff @(posedge iDm9000aClk or posedge iReset) begin
      if (iReset) begin
         oIorReturnValue <= 16'h0000;
      end else if (!oDmIor_n && iorNext) begin
         oIorReturnValue <= iSdIn;
      end
   end

endmodule

// File: tb/tb_dm9000a_reg_access.sv
// Directed bench for dm9000a_reg_access with default timing (S=1, W=2, R=2).
// Latency: checks RunEnd timing against hand-computed clock counts.
// Backpressure: drives the RunStart/RunEnd handshake like a control FSM.
module tb_dm9000a_reg_access;
   import dm9000a_reg_access_pkg::*;

   logic        clk = 1'b0;
   logic        iReset;
   logic        iIowRunStart;
   logic [15:0] iIowReg;
   logic [15:0] iIowData;
   logic        oIowRunEnd;
   logic        iIorRunStart;
   logic [15:0] iIorReg;
   logic        oIorRunEnd;
   logic [15:0] oIorReturnValue;
   logic        oDmCmd;
   logic        oDmCs_n;
   logic        oDmIor_n;
   logic        oDmIow_n;
   logic [15:0] oSdOut;
   logic        oSdOe;
   logic [15:0] iSdIn;
   logic [15:0] rdVal;

   int nCmp = 0;
   int nErr = 0;
   int iowPulses = 0;
   int iorPulses = 0;
   int iowEnds = 0;
   int cyc;
   int base;
   int baseR;
   int baseE;

   // Expected pin trace: {cs, iow, ior, oe, cmd, iowEnd, iorEnd, 0, sd}
   logic [23:0] expSeq [0:11];

   always #5 clk = ~clk;

   // Chip model: drives the read value only while IOR# is low
   assign iSdIn = (oDmIor_n == 1'b0) ? rdVal : 16'hDEAD;

   always @(negedge oDmIow_n) iowPulses++;
   always @(negedge oDmIor_n) iorPulses++;
   always @(posedge oIowRunEnd) iowEnds++;

   dm9000a_reg_access dut (
      .iDm9000aClk     (clk),
      .iReset          (iReset),
      .iIowRunStart    (iIowRunStart),
      .iIowReg         (iIowReg),
      .iIowData        (iIowData),
      .oIowRunEnd      (oIowRunEnd),
      .iIorRunStart    (iIorRunStart),
      .iIorReg         (iIorReg),
      .oIorRunEnd      (oIorRunEnd),
      .oIorReturnValue (oIorReturnValue),
      .oDmCmd          (oDmCmd),
      .oDmCs_n         (oDmCs_n),
      .oDmIor_n        (oDmIor_n),
      .oDmIow_n        (oDmIow_n),
      .oSdOut          (oSdOut),
      .oSdOe           (oSdOe),
      .iSdIn           (iSdIn)
   );

   function automatic logic [23:0] pins();
      return {oDmCs_n, oDmIow_n, oDmIor_n, oSdOe, oDmCmd, oIowRunEnd, oIorRunEnd, 1'b0, oSdOut};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare n consecutive samples (one per clock, starting at the sampling edge)
   task automatic runTable(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         chk($sformatf("%s[%0d]", tag, k), {8'h00, pins()}, {8'h00, expSeq[k]});
      end
   endtask

   // Clocks until the chosen RunEnd rises; -1 if it never does within the budget
   task automatic waitEnd(input bit isWrite, output int n);
      logic prev;
      logic cur;
      bit   seen;
      prev = isWrite ? oIowRunEnd : oIorRunEnd;
      seen = 1'b0;
      n    = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         n++;
         cur = isWrite ? oIowRunEnd : oIorRunEnd;
         if (cur && !prev) seen = 1'b1;
         prev = cur;
      end
      if (!seen) n = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iReset       = 1'b1;
      iIowRunStart = 1'b0;
      iIorRunStart = 1'b0;
      iIowReg      = 16'h0000;
      iIowData     = 16'h0000;
      iIorReg      = 16'h0000;
      rdVal        = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset_pins", {8'h00, pins()}, 32'h00E0_0000);
      chk("reset_rdval", {16'h0, oIorReturnValue}, 32'h0);
      iReset = 1'b0;
      @(negedge clk);

      // Write IMR=0x81: two IOW# pulses of 2 clocks, RunEnd at clock 11
      expSeq = '{24'hE0_0000, 24'h70_00FF, 24'h30_00FF, 24'h30_00FF,
                 24'hF0_00FF, 24'hF0_00FF, 24'h78_0081, 24'h38_0081,
                 24'h38_0081, 24'hF8_0081, 24'hF8_0081, 24'hEC_0081};
      iIowReg      = {8'h00, REG_IMR};
      iIowData     = 16'h0081;
      iIowRunStart = 1'b1;
      runTable("wr_imr", 12);
      iIowRunStart = 1'b0;
      step();
      chk("wr_done_hold", {8'h00, pins()}, 32'h00EC_0081);
      step();
      chk("wr_idle", {8'h00, pins()}, 32'h00E8_0081);

      // Read ISR, chip returns 0x0001; OE stays low in the data phase
      expSeq = '{24'hE8_0081, 24'h70_00FE, 24'h30_00FE, 24'h30_00FE,
                 24'hF0_00FE, 24'hF0_00FE, 24'h68_00FE, 24'h48_00FE,
                 24'h48_00FE, 24'hE8_00FE, 24'hE8_00FE, 24'hEA_00FE};
      base         = iowPulses;
      rdVal        = 16'h0001;
      iIorReg      = {8'h00, REG_ISR};
      iIorRunStart = 1'b1;
      runTable("rd_isr", 12);
      chk("rd_isr_value", {16'h0, oIorReturnValue}, 32'h0001);
      chk("rd_isr_iow_pulses", iowPulses - base, 1);
      iIorRunStart = 1'b0;
      rdVal        = 16'h7777;
      step();
      step();
      chk("rd_value_held", {16'h0, oIorReturnValue}, 32'h0001);

      // Interrupt-handler sequence: write ISR, 1 clock low, write IMR
      base  = iowPulses;
      baseE = iowEnds;
      iIowReg      = {8'h00, REG_ISR};
      iIowData     = 16'h003F;
      iIowRunStart = 1'b1;
      waitEnd(1'b1, cyc);
      chk("seq_wr1_latency", cyc, 12);
      iIowRunStart = 1'b0;
      step();
      iIowReg      = {8'h00, REG_IMR};
      iIowData     = 16'h0080;
      iIowRunStart = 1'b1;
      waitEnd(1'b1, cyc);
      chk("seq_wr2_latency", cyc, 12);
      chk("seq_wr2_sd", {16'h0, oSdOut}, 32'h0080);
      iIowRunStart = 1'b0;
      step();
      step();
      chk("seq_iow_pulses", iowPulses - base, 4);
      chk("seq_run_ends", iowEnds - baseE, 2);

      // RunStart dropped mid-cycle: cycle completes, RunEnd lasts one clock
      iIowReg      = {8'h00, REG_GPR};
      iIowData     = 16'h0001;
      iIowRunStart = 1'b1;
      step();
      step();
      step();
      iIowRunStart = 1'b0;
      iIowData     = 16'hFFFF;
      waitEnd(1'b1, cyc);
      chk("drop_latency", cyc, 9);
      chk("drop_sd_latched", {16'h0, oSdOut}, 32'h0001);
      step();
      chk("drop_end_one_clk", {31'h0, oIowRunEnd}, 32'h0);

      // Both requests at once: write first, read once the write retires
      base  = iowPulses;
      baseR = iorPulses;
      iIowReg      = {8'h00, REG_IMR};
      iIowData     = 16'h0055;
      iIorReg      = {8'h00, REG_MRCMD};
      rdVal        = 16'hA5A5;
      iIowRunStart = 1'b1;
      iIorRunStart = 1'b1;
      waitEnd(1'b1, cyc);
      chk("both_wr_latency", cyc, 12);
      chk("both_no_read_yet", iorPulses - baseR, 0);
      iIowRunStart = 1'b0;
      waitEnd(1'b0, cyc);
      chk("both_rd_latency", cyc, 13);
      chk("both_rd_value", {16'h0, oIorReturnValue}, 32'hA5A5);
      iIorRunStart = 1'b0;
      step();
      step();
      chk("both_iow_pulses", iowPulses - base, 3);
      chk("both_ior_pulses", iorPulses - baseR, 1);

      // Reset in the middle of DAT_STROBE forces pins idle at once
      iIowReg      = {8'h00, REG_IMR};
      iIowData     = 16'h000F;
      iIowRunStart = 1'b1;
      repeat (8) step();
      chk("rst_mid_strobe_before", {8'h00, pins()}, 32'h0038_000F);
      #2;
      iReset = 1'b1;
      #1;
      chk("rst_mid_strobe_pins", {28'h0, oDmCs_n, oDmIow_n, oDmIor_n, oSdOe}, 32'hE);
      chk("rst_mid_rdval", {16'h0, oIorReturnValue}, 32'h0);
      iIowRunStart = 1'b0;
      @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      chk("rst_after_pins", {8'h00, pins()}, 32'h00E0_0000);

      // Two reads of the same index
      base         = iowPulses;
      rdVal        = 16'h0003;
      iIorReg      = {8'h00, REG_ISR};
      iIorRunStart = 1'b1;
      waitEnd(1'b0, cyc);
      chk("rpt_rd1_latency", cyc, 12);
      iIorRunStart = 1'b0;
      step();
      iIorRunStart = 1'b1;
      waitEnd(1'b0, cyc);
`ifdef DM9000A_INDEX_CACHE_EN
      chk("rpt_rd2_latency_cached", cyc, 7);
`else
      chk("rpt_rd2_latency", cyc, 12);
`endif
      chk("rpt_rd2_value", {16'h0, oIorReturnValue}, 32'h0003);
      iIorRunStart = 1'b0;
      step();
      step();
`ifdef DM9000A_INDEX_CACHE_EN
      chk("rpt_iow_pulses_cached", iowPulses - base, 1);
      // Reset invalidates the cache: index is written again
      iReset = 1'b1;
      @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      base         = iowPulses;
      iIorRunStart = 1'b1;
      waitEnd(1'b0, cyc);
      chk("cache_rst_rd_latency", cyc, 12);
      iIorRunStart = 1'b0;
      step();
      step();
      chk("cache_rst_iow_pulses", iowPulses - base, 1);
`else
      chk("rpt_iow_pulses", iowPulses - base, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
